// File: rtl/var_mul_pkg.sv
// Shared types and helpers for the run-skipping Booth multiplier.
// Holds the FSM state encoding and the derived count width.
package var_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough to hold any value in 0..width (scan position and cycle count).
  function automatic int cyc_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/var_latency_booth_mul_if.sv
// Controller-facing bundle of the multiplier: start handshake, operands and completion.
// Handshake: a request transfers on a clock edge where start_valid && start_ready; operands are sampled then.
interface var_latency_booth_mul_if
  import var_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CYC_W = cyc_w(WIDTH)
) ();

  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic [2*WIDTH-1:0]   result;
  logic                 done;
  logic                 busy;
  logic [CYC_W-1:0]     cycles;
  state_e               dbg_state;

  modport master (
    output start_valid, a, b, signed_mode,
    input  start_ready, result, done, busy, cycles, dbg_state
  );

  modport slave (
    input  start_valid, a, b, signed_mode,
    output start_ready, result, done, busy, cycles, dbg_state
  );

endinterface

// File: rtl/var_mul_run_detect.sv
// Windowed priority encoder: finds the lowest bit at or above pos, within MAX_SKIP
// positions and below WIDTH, whose value differs from the current run value q.
module var_mul_run_detect
  import var_mul_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_SKIP = 16,
  parameter int POS_W    = cyc_w(WIDTH)
) (
  input  logic [WIDTH-1:0] a_r,
  input  logic [POS_W-1:0] pos,
  input  logic             q,
  output logic             found,
  output logic [POS_W-1:0] k,
  output logic [POS_W-1:0] next_pos
);

  int win_end;

  always_comb begin
    win_end = int'(pos) + MAX_SKIP;
    if (win_end > WIDTH) win_end = WIDTH;
    found = 1'b0;
    k     = '0;
    // Descending sweep so the lowest matching index is the one left standing.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i >= int'(pos) && i < win_end && a_r[i] != q) begin
        found = 1'b1;
        k     = POS_W'(i);
      end
    end
    next_pos = found ? (k + POS_W'(1)) : POS_W'(win_end);
  end

endmodule

// File: rtl/var_latency_booth_mul.sv
// Variable-latency multiplier: one add/subtract of the shifted multiplicand per run
// boundary in a, so latency follows the number of bit transitions in a.
module var_latency_booth_mul
  import var_mul_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_SKIP = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  var_latency_booth_mul_if.slave bus
);

  localparam int CYC_W = cyc_w(WIDTH);
  localparam int ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [ACC_W-1:0]   b_ext_q, b_ext_d;
  logic               mode_q, mode_d;
  logic [CYC_W-1:0]   pos_q, pos_d;
  logic               q_q, q_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;

  logic               found;
  logic [CYC_W-1:0]   k;
  logic [CYC_W-1:0]   next_pos;

  var_mul_run_detect #(
    .WIDTH    (WIDTH),
    .MAX_SKIP (MAX_SKIP),
    .POS_W    (CYC_W)
  ) u_run_detect (
    .a_r      (a_q),
    .pos      (pos_q),
    .q        (q_q),
    .found    (found),
    .k        (k),
    .next_pos (next_pos)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_ext_d  = b_ext_q;
    mode_d   = mode_q;
    pos_d    = pos_q;
    q_d      = q_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cycles_d = cycles_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_ext_d = bus.signed_mode ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b}
                                    : {{WIDTH{1'b0}}, bus.b};
          mode_d  = bus.signed_mode;
          pos_d   = '0;
          q_d     = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CYC_W'(1);
        pos_d = next_pos;
        // Entering a run of ones subtracts, leaving one adds back.
        if (found) begin
          q_d   = ~q_q;
          acc_d = q_q ? (acc_q + (b_ext_q << k)) : (acc_q - (b_ext_q << k));
        end
        if (next_pos == CYC_W'(WIDTH)) begin
          // An unsigned run of ones reaching the MSB closes at bit WIDTH.
          if (q_d && !mode_q) acc_d = acc_d + (b_ext_q << WIDTH);
          result_d = acc_d;
          cycles_d = cnt_d;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_ext_q  <= '0;
      mode_q   <= 1'b0;
      pos_q    <= '0;
      q_q      <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_ext_q  <= b_ext_d;
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = result_q;
  assign bus.cycles      = cycles_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_var_latency_booth_mul.sv
// Bench for var_latency_booth_mul: directed vector table, multi-cycle corner sequences,
// and random operands against an arithmetic reference on 16-bit and 8-bit instances.
module tb_var_latency_booth_mul;
  import var_mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  var_latency_booth_mul_if #(.WIDTH(16)) bif16 ();
  var_latency_booth_mul_if #(.WIDTH(16)) bif4 ();
  var_latency_booth_mul_if #(.WIDTH(8))  bif8 ();

  // The MAX_SKIP=4 instance sees exactly the same requests as the main one.
  assign bif4.start_valid = bif16.start_valid;
  assign bif4.a           = bif16.a;
  assign bif4.b           = bif16.b;
  assign bif4.signed_mode = bif16.signed_mode;

  var_latency_booth_mul #(.WIDTH(16), .MAX_SKIP(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bif16.slave));
  var_latency_booth_mul #(.WIDTH(16), .MAX_SKIP(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bif4.slave));
  var_latency_booth_mul #(.WIDTH(8),  .MAX_SKIP(3))  u_dut8  (.clk(clk), .rst(rst), .bus(bif8.slave));

  int checks = 0;
  int errors = 0;

  // done must never stay high on two consecutive cycles
  int   pulse_err16 = 0, pulse_err4 = 0, pulse_err8 = 0;
  logic prev16 = 1'b0, prev4 = 1'b0, prev8 = 1'b0;
  int   acc16 = 0;

  always @(negedge clk) begin
    if (bif16.done && prev16) pulse_err16 <= pulse_err16 + 1;
    if (bif4.done  && prev4)  pulse_err4  <= pulse_err4 + 1;
    if (bif8.done  && prev8)  pulse_err8  <= pulse_err8 + 1;
    prev16 <= bif16.done;
    prev4  <= bif4.done;
    prev8  <= bif8.done;
  end

  always @(posedge clk) begin
    if (!rst && bif16.start_valid && bif16.start_ready) acc16 <= acc16 + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: product from plain modular arithmetic; cycle count from the run structure
  // of a (each boundary costs ceil(distance/skip) windows, then the tail is swept).
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic m,
                                input int w, input int skip,
                                output logic [31:0] p, output int cyc);
    longint sa, sb, prod, mask;
    int pos, prev, bitv;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (m && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
    if (m && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
    prod = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    p = 32'(prod);
    pos = 0; prev = 0; cyc = 0;
    for (int i = 0; i < w; i++) begin
      bitv = int'(a[i]);
      if (bitv != prev) begin
        cyc  = cyc + (i - pos) / skip + 1;
        pos  = i + 1;
        prev = bitv;
      end
    end
    if (pos < w) cyc = cyc + (w - pos + skip - 1) / skip;
  endfunction

  // One request to both 16-bit instances; latency counted in clocks after acceptance.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m, input bit hold,
                      output logic [31:0] r0, output int c0, output int l0,
                      output logic [31:0] r1, output int c1, output int l1);
    r0 = 'x; r1 = 'x; c0 = -1; c1 = -1; l0 = -1; l1 = -1;
    @(negedge clk);
    bif16.start_valid = 1'b1;
    bif16.a = a;
    bif16.b = b;
    bif16.signed_mode = m;
    @(posedge clk);
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) bif16.start_valid = 1'b0;
      if (bif16.done && l0 < 0) begin
        l0 = n; r0 = bif16.result; c0 = int'(bif16.cycles);
        if (hold) bif16.start_valid = 1'b0;
      end
      if (bif4.done && l1 < 0) begin
        l1 = n; r1 = bif4.result; c1 = int'(bif4.cycles);
      end
      if (l0 >= 0 && l1 >= 0) break;
    end
    bif16.start_valid = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     output logic [15:0] r, output int c, output int l);
    r = 'x; c = -1; l = -1;
    @(negedge clk);
    bif8.start_valid = 1'b1;
    bif8.a = a;
    bif8.b = b;
    bif8.signed_mode = m;
    @(posedge clk);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n == 1) bif8.start_valid = 1'b0;
      if (bif8.done) begin
        l = n; r = bif8.result; c = int'(bif8.cycles);
        break;
      end
    end
    bif8.start_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [31:0] r;
    int          c;
    int          c4;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] r0, r1, er, er4;
  logic [15:0] r8;
  logic [15:0] ra, rb;
  logic        rm;
  int          c0, c1, l0, l1, c8, l8, ec, ec4, acc_before, sel;
  bit          saw_done;

  initial begin
    tbl[0] = '{16'h00FF, 16'h0003, 1'b1, 32'h000002FD,  3,  5};
    tbl[1] = '{16'hFFFF, 16'h0007, 1'b1, 32'hFFFFFFF9,  2,  5};
    tbl[2] = '{16'hFFFF, 16'h0007, 1'b0, 32'h0006FFF9,  2,  5};
    tbl[3] = '{16'h5555, 16'hFFFE, 1'b1, 32'hFFFF5556, 16, 16};
    tbl[4] = '{16'hAAAA, 16'h0001, 1'b1, 32'hFFFFAAAA, 15, 15};
    tbl[5] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000,  1,  4};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000,  1,  4};
    tbl[7] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000,  1,  4};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001,  2,  5};

    bif16.start_valid = 1'b0; bif16.a = '0; bif16.b = '0; bif16.signed_mode = 1'b0;
    bif8.start_valid  = 1'b0; bif8.a  = '0; bif8.b  = '0; bif8.signed_mode  = 1'b0;

    // Reset, with a request held during it: reset must win.
    repeat (3) @(posedge clk);
    @(negedge clk);
    bif16.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(bif16.result), 64'h0);
    chk("rst_cycles", 64'(bif16.cycles), 64'h0);
    chk("rst_done", 64'(bif16.done), 64'h0);
    chk("rst_busy", 64'(bif16.busy), 64'h0);
    chk("rst_ready", 64'(bif16.start_ready), 64'h1);
    chk("rst_busy8", 64'(bif8.busy), 64'h0);
    bif16.start_valid = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) begin
      op16(tbl[i].a, tbl[i].b, tbl[i].m, 1'b0, r0, c0, l0, r1, c1, l1);
      chk($sformatf("tbl%0d_result", i), 64'(r0), 64'(tbl[i].r));
      chk($sformatf("tbl%0d_cycles", i), 64'(c0), 64'(tbl[i].c));
      chk($sformatf("tbl%0d_latency", i), 64'(l0), 64'(tbl[i].c + 1));
      chk($sformatf("tbl%0d_result_s4", i), 64'(r1), 64'(tbl[i].r));
      chk($sformatf("tbl%0d_cycles_s4", i), 64'(c1), 64'(tbl[i].c4));
    end

    // start_valid held through the whole operation: only one acceptance.
    acc_before = acc16;
    op16(16'h0F0F, 16'h0011, 1'b0, 1'b1, r0, c0, l0, r1, c1, l1);
    model(16'h0F0F, 16'h0011, 1'b0, 16, 16, er, ec);
    chk("hold_result", 64'(r0), 64'(er));
    chk("hold_cycles", 64'(c0), 64'(ec));
    chk("hold_accepts", 64'(acc16 - acc_before), 64'd1);

    // Reset in the 5th SCAN cycle aborts without a done pulse.
    @(negedge clk);
    @(negedge clk);
    bif16.start_valid = 1'b1;
    bif16.a = 16'h5555;
    bif16.b = 16'h1234;
    bif16.signed_mode = 1'b1;
    @(posedge clk);
    saw_done = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bif16.start_valid = 1'b0;
      if (bif16.done) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_no_done", 64'(saw_done), 64'h0);
    chk("abort_done", 64'(bif16.done), 64'h0);
    chk("abort_result", 64'(bif16.result), 64'h0);
    chk("abort_cycles", 64'(bif16.cycles), 64'h0);
    chk("abort_busy", 64'(bif16.busy), 64'h0);
    chk("abort_ready", 64'(bif16.start_ready), 64'h1);

    op16(16'h0002, 16'h0005, 1'b1, 1'b0, r0, c0, l0, r1, c1, l1);
    chk("post_abort_result", 64'(r0), 64'd10);
    chk("post_abort_cycles", 64'(c0), 64'd3);
    chk("post_abort_latency", 64'(l0), 64'd4);
    chk("post_abort_cycles_s4", 64'(c1), 64'd6);

    // Random operands on the 16-bit pair.
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 3);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      if (sel == 1) ra = (16'hFFFF << $urandom_range(0, 15)) ^ (16'hFFFF << $urandom_range(0, 15));
      if (sel == 2) ra = 16'h5555 ^ (16'h1 << $urandom_range(0, 15));
      op16(ra, rb, rm, 1'b0, r0, c0, l0, r1, c1, l1);
      model(ra, rb, rm, 16, 16, er, ec);
      model(ra, rb, rm, 16, 4, er4, ec4);
      chk("rnd16_result", 64'(r0), 64'(er));
      chk("rnd16_cycles", 64'(c0), 64'(ec));
      chk("rnd16_latency", 64'(l0), 64'(ec + 1));
      chk("rnd16s4_result", 64'(r1), 64'(er4));
      chk("rnd16s4_cycles", 64'(c1), 64'(ec4));
    end

    // Random operands on the 8-bit instance.
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      op8(ra[7:0], rb[7:0], rm, r8, c8, l8);
      model(ra, rb, rm, 8, 3, er, ec);
      chk("rnd8_result", 64'(r8), 64'(er));
      chk("rnd8_cycles", 64'(c8), 64'(ec));
      chk("rnd8_latency", 64'(l8), 64'(ec + 1));
    end

    repeat (2) @(negedge clk);
    chk("done_pulse16", 64'(pulse_err16), 64'h0);
    chk("done_pulse4", 64'(pulse_err4), 64'h0);
    chk("done_pulse8", 64'(pulse_err8), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
